// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: sequencer states and the opcodes the
// control unit branches on. The instruction decoder imports the same package.
package cpu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_REGREAD   = 3'd2,
        ST_ALU       = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on memory and flags when the wait budget runs out.
// A MEM_TIMEOUT of 0 disables expiry; the counter saturates rather than wrapping.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic clk,
    input  logic clear,
    input  logic count,
    input  logic ready,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 waiting;

    assign waiting = count & ~ready;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    // A ready on the final allowed cycle takes priority, so expiry needs !ready.
    assign expired = (MEM_TIMEOUT != 0) & waiting & (cnt_q == LIMIT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: walks each instruction through fetch, decode, register
// read, ALU, memory and writeback, raising exactly one stage enable per cycle.
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                I_clk,
    input  logic                I_reset,
    input  logic                I_enable,
    input  logic [OPCODE_W-1:0] I_opcode,
    input  logic                I_mem_ready,
    output logic                O_en_fetch,
    output logic                O_en_decode,
    output logic                O_en_regread,
    output logic                O_en_alu,
    output logic                O_en_mem,
    output logic                O_en_writeback,
    output logic                O_mem_req,
    output logic                O_mem_write,
    output logic                O_halted,
    output logic                O_fault
);

    state_e state_q;
    state_e state_d;
    logic   fault_q;
    logic   fault_d;
    logic   wd_clear;
    logic   wd_count;
    logic   wd_expired;
    logic   run;

    // The wait counter restarts on every state change and whenever reset is held.
    assign wd_clear = I_reset | (state_d != state_q);
    assign wd_count = I_enable & ((state_q == ST_FETCH) | (state_q == ST_MEM));

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_mem_watchdog (
        .clk     (I_clk),
        .clear   (wd_clear),
        .count   (wd_count),
        .ready   (I_mem_ready),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        if (I_enable) begin
            case (state_q)
                ST_FETCH: begin
                    if (I_mem_ready) begin
                        state_d = ST_DECODE;
                    end else if (wd_expired) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end
                end
                ST_DECODE:  state_d = ST_REGREAD;
                ST_REGREAD: state_d = ST_ALU;
                ST_ALU: begin
                    case (I_opcode)
                        OP_HALT:           state_d = ST_HALT;
                        OP_LOAD, OP_STORE: state_d = ST_MEM;
                        OP_JUMP:           state_d = ST_FETCH;
                        default:           state_d = ST_WRITEBACK;
                    endcase
                end
                ST_MEM: begin
                    if (I_mem_ready) begin
                        state_d = (I_opcode == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
                    end else if (wd_expired) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end
                end
                ST_WRITEBACK: state_d = ST_FETCH;
                ST_HALT:      state_d = ST_HALT;
                default:      state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Halted and fault report status, so they ignore I_enable but not reset.
    assign run            = I_enable & ~I_reset;
    assign O_en_fetch     = run & (state_q == ST_FETCH);
    assign O_en_decode    = run & (state_q == ST_DECODE);
    assign O_en_regread   = run & (state_q == ST_REGREAD);
    assign O_en_alu       = run & (state_q == ST_ALU);
    assign O_en_mem       = run & (state_q == ST_MEM);
    assign O_en_writeback = run & (state_q == ST_WRITEBACK);
    assign O_mem_req      = run & ((state_q == ST_FETCH) | (state_q == ST_MEM));
    assign O_mem_write    = run & (state_q == ST_MEM) & (I_opcode == OP_STORE);
    assign O_halted       = ~I_reset & (state_q == ST_HALT);
    assign O_fault        = ~I_reset & fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a short memory watchdog; every cycle the
// full output vector is compared against a hand-derived expectation.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] opcode;
    logic       memReady;

    logic enFetch, enDecode, enRegread, enAlu, enMem, enWriteback;
    logic memReq, memWrite, halted, fault;

    int vectors     = 0;
    int miscompares = 0;

    // Output vector order: fetch decode regread alu mem writeback req write halted fault
    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_FETCH  = 10'b1000001000;
    localparam logic [9:0] V_DECODE = 10'b0100000000;
    localparam logic [9:0] V_RREAD  = 10'b0010000000;
    localparam logic [9:0] V_ALU    = 10'b0001000000;
    localparam logic [9:0] V_MEMRD  = 10'b0000101000;
    localparam logic [9:0] V_MEMWR  = 10'b0000101100;
    localparam logic [9:0] V_WB     = 10'b0000010000;
    localparam logic [9:0] V_HALT   = 10'b0000000010;
    localparam logic [9:0] V_FAULT  = 10'b0000000011;

    localparam logic [3:0] OPA = 4'h1;
    localparam logic [3:0] LD  = 4'hA;
    localparam logic [3:0] ST  = 4'hB;
    localparam logic [3:0] JMP = 4'hC;
    localparam logic [3:0] HLT = 4'hF;

    always #5 clk = ~clk;

    control_unit #(
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (5)
    ) dut (
        .I_clk          (clk),
        .I_reset        (reset),
        .I_enable       (enable),
        .I_opcode       (opcode),
        .I_mem_ready    (memReady),
        .O_en_fetch     (enFetch),
        .O_en_decode    (enDecode),
        .O_en_regread   (enRegread),
        .O_en_alu       (enAlu),
        .O_en_mem       (enMem),
        .O_en_writeback (enWriteback),
        .O_mem_req      (memReq),
        .O_mem_write    (memWrite),
        .O_halted       (halted),
        .O_fault        (fault)
    );

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs mid-period, then checks the combinational outputs
    // before the next rising edge commits the transition.
    task automatic applyStimulus(input logic rst, input logic en, input logic rdy,
                                 input logic [3:0] op, input logic [9:0] exp, input string tag);
        @(negedge clk);
        reset    = rst;
        enable   = en;
        memReady = rdy;
        opcode   = op;
        #1;
        checkOutput(tag, {enFetch, enDecode, enRegread, enAlu, enMem, enWriteback,
                          memReq, memWrite, halted, fault}, exp);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        memReady = 1'b1;
        opcode   = OPA;

        applyStimulus(1, 1, 1, OPA, V_IDLE,   "reset0");
        applyStimulus(1, 1, 1, OPA, V_IDLE,   "reset1");

        applyStimulus(0, 1, 1, OPA, V_FETCH,  "alu_fetch");
        applyStimulus(0, 1, 1, OPA, V_DECODE, "alu_decode");
        applyStimulus(0, 1, 1, OPA, V_RREAD,  "alu_regread");
        applyStimulus(0, 1, 1, OPA, V_ALU,    "alu_alu");
        applyStimulus(0, 1, 1, OPA, V_WB,     "alu_wb");

        applyStimulus(0, 1, 1, LD,  V_FETCH,  "ld_fetch");
        applyStimulus(0, 1, 1, LD,  V_DECODE, "ld_decode");
        applyStimulus(0, 1, 1, LD,  V_RREAD,  "ld_regread");
        applyStimulus(0, 1, 1, LD,  V_ALU,    "ld_alu");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, LD, V_MEMRD, "ld_memwait");
        applyStimulus(0, 1, 1, LD,  V_MEMRD,  "ld_memready_at_limit");
        applyStimulus(0, 1, 1, LD,  V_WB,     "ld_wb");

        applyStimulus(0, 1, 1, ST,  V_FETCH,  "st_fetch");
        applyStimulus(0, 1, 1, ST,  V_DECODE, "st_decode");
        applyStimulus(0, 1, 1, ST,  V_RREAD,  "st_regread");
        applyStimulus(0, 1, 1, ST,  V_ALU,    "st_alu");
        applyStimulus(0, 1, 1, ST,  V_MEMWR,  "st_mem");

        applyStimulus(0, 1, 1, OPA, V_FETCH,  "frz_fetch");
        applyStimulus(0, 1, 1, OPA, V_DECODE, "frz_decode");
        applyStimulus(0, 1, 1, OPA, V_RREAD,  "frz_regread");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 1, OPA, V_IDLE, "frz_hold");
        applyStimulus(0, 1, 1, OPA, V_ALU,    "frz_resume_alu");
        applyStimulus(0, 1, 1, OPA, V_WB,     "frz_wb");

        applyStimulus(0, 1, 1, JMP, V_FETCH,  "jmp_fetch");
        applyStimulus(0, 1, 1, JMP, V_DECODE, "jmp_decode");
        applyStimulus(0, 1, 1, JMP, V_RREAD,  "jmp_regread");
        applyStimulus(0, 1, 1, JMP, V_ALU,    "jmp_alu");

        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, OPA, V_FETCH, "wd_fetchwait");
        applyStimulus(0, 1, 1, OPA, V_FAULT,  "wd_halted");
        applyStimulus(0, 1, 1, OPA, V_FAULT,  "wd_sticky");
        applyStimulus(0, 0, 1, OPA, V_FAULT,  "wd_sticky_disabled");
        applyStimulus(1, 1, 1, OPA, V_IDLE,   "wd_reset");

        applyStimulus(0, 1, 1, HLT, V_FETCH,  "hlt_fetch");
        applyStimulus(0, 1, 1, HLT, V_DECODE, "hlt_decode");
        applyStimulus(0, 1, 1, HLT, V_RREAD,  "hlt_regread");
        applyStimulus(0, 1, 1, HLT, V_ALU,    "hlt_alu");
        applyStimulus(0, 1, 1, HLT, V_HALT,   "hlt_halted");
        applyStimulus(0, 1, 0, HLT, V_HALT,   "hlt_terminal");
        applyStimulus(1, 1, 1, HLT, V_IDLE,   "hlt_reset");

        applyStimulus(0, 1, 1, LD,  V_FETCH,  "rst_fetch");
        applyStimulus(0, 1, 1, LD,  V_DECODE, "rst_decode");
        applyStimulus(0, 1, 1, LD,  V_RREAD,  "rst_regread");
        applyStimulus(0, 1, 1, LD,  V_ALU,    "rst_alu");
        applyStimulus(0, 1, 0, LD,  V_MEMRD,  "rst_memwait");
        applyStimulus(1, 1, 0, LD,  V_IDLE,   "rst_mid_mem");
        applyStimulus(0, 1, 1, LD,  V_FETCH,  "rst_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
